// File: rtl/logs_r_sequencer_pkg.sv
// Package for the logistic-map r sequencer.
// Contents: the FSM state encoding, the r bit patterns that pick reduced
// oscillator counts, and small constant helpers used to size the design.
package logs_r_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_SETTLE = 2'd0,
    ST_PLAY   = 2'd1,
    ST_STEP   = 2'd2
  } state_t;

  // r bit patterns (top bits of r, integer part first) for the reduced-count regions
  localparam logic [7:0] REGION6_A = 8'b11_101000;  // r[FRAC+1:FRAC-6]
  localparam logic [5:0] REGION6_B = 6'b11_1101;    // r[FRAC+1:FRAC-4]
  localparam logic [6:0] REGION5   = 7'b11_10111;   // r[FRAC+1:FRAC-5]

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Largest multiple of 6 not above n (n itself when fewer than 6 oscillators)
  function automatic int n_osc_6(input int n);
    return (n < 6) ? n : 6 * (n / 6);
  endfunction

  // Largest multiple of 5 not above n (n itself when fewer than 5 oscillators)
  function automatic int n_osc_5(input int n);
    return (n < 5) ? n : 5 * (n / 5);
  endfunction

endpackage

// File: rtl/logs_r_sequencer_if.sv
// Interface between the r sequencer and the rest of the sonification datapath.
// Ports (as signals):
//   next_ready, hold, manual, step_up, step_down : into the sequencer
//   r, x_accept, r_changed, max_n_osc, osc_mask   : out of the sequencer
// Modports: master = the sequencer, slave = iterator/NCO/mixer/user side.
interface logs_r_sequencer_if #(
  parameter int N_OSC = 4,
  parameter int FRAC  = 8
);
  localparam int FC_LEN = (N_OSC > 1) ? $clog2(N_OSC) : 1;

  logic              next_ready;
  logic              hold;
  logic              manual;
  logic              step_up;
  logic              step_down;
  logic [FRAC+1:0]   r;
  logic              x_accept;
  logic              r_changed;
  logic [FC_LEN-1:0] max_n_osc;
  logic [N_OSC-1:0]  osc_mask;

  modport master (
    input  next_ready, hold, manual, step_up, step_down,
    output r, x_accept, r_changed, max_n_osc, osc_mask
  );

  modport slave (
    output next_ready, hold, manual, step_up, step_down,
    input  r, x_accept, r_changed, max_n_osc, osc_mask
  );
endinterface

// File: rtl/logs_r_sequencer_osc_region.sv
// logs_osc_region: combinational decode of r into the active oscillator set.
// Ports:
//   r          in  FRAC+2  r value (2.FRAC fixed point)
//   max_n_osc  out FC_LEN  active oscillator count minus one
//   osc_mask   out N_OSC   low 'count' bits set
// Requires FRAC >= 6 so all pattern bits exist.
module logs_osc_region
  import logs_r_sequencer_pkg::*;
#(
  parameter int N_OSC  = 4,
  parameter int FRAC   = 8,
  parameter int FC_LEN = (N_OSC > 1) ? $clog2(N_OSC) : 1
) (
  input  logic [FRAC+1:0]   r,
  output logic [FC_LEN-1:0] max_n_osc,
  output logic [N_OSC-1:0]  osc_mask
);

  localparam int N6 = n_osc_6(N_OSC);
  localparam int N5 = n_osc_5(N_OSC);

  int count_s;

  // Region match and conversion of the count into max index and thermometer mask
  always_comb begin
    count_s   = N_OSC;
    max_n_osc = '0;
    osc_mask  = '0;
    if (r[FRAC+1:FRAC-6] == REGION6_A) begin
      count_s = N6;
    end else if ((r[FRAC+1:FRAC-4] == REGION6_B) && !(&r[FRAC-5:FRAC-6])) begin
      count_s = N6;
    end else if (r[FRAC+1:FRAC-5] == REGION5) begin
      count_s = N5;
    end else begin
      count_s = N_OSC;
    end
    max_n_osc = FC_LEN'(count_s - 1);
    for (int i = 0; i < N_OSC; i++) begin
      osc_mask[i] = (i < count_s);
    end
  end

endmodule

// File: rtl/logs_r_sequencer.sv
// logs_r_sequencer: owns the logistic-map 'r' register. Auto mode sweeps r up
// after PLAY_ITERS accepted iterations; manual mode steps r on user pulses.
// After every r update the first SETTLE_ITERS iterations are discarded
// (x_accept low) so only settled x values reach the NCO frequency loader.
// Ports:
//   clk    in  clock
//   reset  in  synchronous, active-high reset
//   bus    master modport: next_ready/hold/manual/step_up/step_down in;
//          r/x_accept/r_changed/max_n_osc/osc_mask out (all registered)
module logs_r_sequencer
  import logs_r_sequencer_pkg::*;
#(
  parameter int N_OSC        = 4,
  parameter int FRAC         = 8,
  parameter int SETTLE_ITERS = 16,
  parameter int PLAY_ITERS   = 1000,
  parameter int INITIAL_R    = (1 << FRAC) | (1 << (FRAC - 4))
) (
  input logic                 clk,
  input logic                 reset,
  logs_r_sequencer_if.master  bus
);

  localparam int FC_LEN = (N_OSC > 1) ? $clog2(N_OSC) : 1;
  localparam int CNT_W  = $clog2(max_int(SETTLE_ITERS, PLAY_ITERS) + 1);

  localparam logic [FRAC+1:0] INIT_R      = (FRAC+2)'(INITIAL_R);
  localparam logic [CNT_W-1:0] SETTLE_LAST =
    (SETTLE_ITERS > 0) ? CNT_W'(SETTLE_ITERS - 1) : CNT_W'(0);
  localparam logic [CNT_W-1:0] PLAY_LAST   = CNT_W'(PLAY_ITERS - 1);
  localparam state_t          START_STATE = (SETTLE_ITERS == 0) ? ST_PLAY : ST_SETTLE;
  localparam logic [FRAC+2:0] DELTA_4     = (FRAC+3)'(4);
  localparam logic [FRAC+2:0] DELTA_1     = (FRAC+3)'(1);

  state_t            state_r, state_s;
  logic [CNT_W-1:0]  cnt_r, cnt_s;
  logic              dir_up_r, dir_up_s;
  logic [FRAC+1:0]   r_r;
  logic              x_accept_r;
  logic              r_changed_r;
  logic [FC_LEN-1:0] max_n_osc_r;
  logic [N_OSC-1:0]  osc_mask_r;

  logic              step_req_s;
  logic              count_s;
  logic [FRAC+2:0]   inc_s, dec_s, sum_s, diff_s;
  logic [FRAC+1:0]   r_new_s;
  logic [FC_LEN-1:0] region_max_s;
  logic [N_OSC-1:0]  region_mask_s;

  // Next-state and iteration-count logic
  always_comb begin
    state_s    = state_r;
    cnt_s      = cnt_r;
    dir_up_s   = dir_up_r;
    step_req_s = bus.manual && (bus.step_up ^ bus.step_down);
    count_s    = bus.next_ready && !bus.hold;
    case (state_r)
      ST_SETTLE: begin
        if (step_req_s) begin
          state_s  = ST_STEP;
          dir_up_s = bus.step_up;
          cnt_s    = '0;
        end else if (count_s) begin
          if (cnt_r == SETTLE_LAST) begin
            state_s = ST_PLAY;
            cnt_s   = '0;
          end else begin
            cnt_s = cnt_r + CNT_W'(1);
          end
        end else begin
          cnt_s = cnt_r;
        end
      end
      ST_PLAY: begin
        if (step_req_s) begin
          state_s  = ST_STEP;
          dir_up_s = bus.step_up;
          cnt_s    = '0;
        end else if (count_s) begin
          if (cnt_r == PLAY_LAST) begin
            // In manual mode the count parks at its last value and PLAY continues
            if (!bus.manual) begin
              state_s  = ST_STEP;
              dir_up_s = 1'b1;
              cnt_s    = '0;
            end else begin
              cnt_s = cnt_r;
            end
          end else begin
            cnt_s = cnt_r + CNT_W'(1);
          end
        end else begin
          cnt_s = cnt_r;
        end
      end
      ST_STEP: begin
        state_s = START_STATE;
        cnt_s   = '0;
      end
      default: begin
        state_s = START_STATE;
        cnt_s   = '0;
      end
    endcase
  end

  // r step arithmetic: coarse steps below 3.0, fine steps above; wrap on overflow, clamp at the floor
  always_comb begin
    inc_s  = (r_r[FRAC+1:FRAC] != 2'b11) ? DELTA_4 : DELTA_1;
    dec_s  = ((r_r[FRAC+1:FRAC] == 2'b11) && (|r_r[FRAC-1:0])) ? DELTA_1 : DELTA_4;
    sum_s  = {1'b0, r_r} + inc_s;
    diff_s = {1'b0, r_r} - dec_s;
    if (dir_up_r) begin
      r_new_s = sum_s[FRAC+2] ? INIT_R : sum_s[FRAC+1:0];
    end else begin
      r_new_s = (diff_s[FRAC+2] || (diff_s[FRAC+1:0] < INIT_R)) ? INIT_R : diff_s[FRAC+1:0];
    end
  end

  logs_osc_region #(
    .N_OSC  (N_OSC),
    .FRAC   (FRAC),
    .FC_LEN (FC_LEN)
  ) u_region (
    .r         (r_new_s),
    .max_n_osc (region_max_s),
    .osc_mask  (region_mask_s)
  );

  // State, counter and output registers; r and the oscillator set load only in STEP
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= START_STATE;
      cnt_r       <= '0;
      dir_up_r    <= 1'b1;
      r_r         <= INIT_R;
      x_accept_r  <= (SETTLE_ITERS == 0);
      r_changed_r <= 1'b0;
      max_n_osc_r <= FC_LEN'(N_OSC - 1);
      osc_mask_r  <= '1;
    end else begin
      state_r    <= state_s;
      cnt_r      <= cnt_s;
      dir_up_r   <= dir_up_s;
      x_accept_r <= (state_s == ST_PLAY);
      if (state_r == ST_STEP) begin
        r_r         <= r_new_s;
        r_changed_r <= (r_new_s != r_r);
        max_n_osc_r <= region_max_s;
        osc_mask_r  <= region_mask_s;
      end else begin
        r_changed_r <= 1'b0;
      end
    end
  end

  assign bus.r         = r_r;
  assign bus.x_accept  = x_accept_r;
  assign bus.r_changed = r_changed_r;
  assign bus.max_n_osc = max_n_osc_r;
  assign bus.osc_mask  = osc_mask_r;

endmodule

// File: tb/tb_logs_r_sequencer.sv
// Self-checking bench for logs_r_sequencer (FRAC=8, N_OSC=8, SETTLE_ITERS=2,
// PLAY_ITERS=3). A table of manual step-up checkpoints covers the region
// decode; hand-written sequences cover auto stepping, clamping, hold and reset.
module tb_logs_r_sequencer;

  logic clk;
  logic reset;
  int   pass_cnt;
  int   total_cnt;

  logs_r_sequencer_if #(.N_OSC(8), .FRAC(8)) bus ();

  logs_r_sequencer #(
    .N_OSC        (8),
    .FRAC         (8),
    .SETTLE_ITERS (2),
    .PLAY_ITERS   (3),
    .INITIAL_R    (272)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         n_steps;
    logic [9:0] exp_r;
    logic [2:0] exp_max;
    logic [7:0] exp_mask;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // one-cycle next_ready pulse; returns #1 after the edge that samples it
  task automatic pulse();
    bus.next_ready = 1'b1;
    @(posedge clk); #1;
    bus.next_ready = 1'b0;
  endtask

  // manual step pulse, then wait through the STEP cycle
  task automatic do_step(input logic up);
    bus.step_up   = up;
    bus.step_down = ~up;
    @(posedge clk); #1;
    bus.step_up   = 1'b0;
    bus.step_down = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_r"},         32'(bus.r),         32'h110);
    check({tag, "_x_accept"},  32'(bus.x_accept),  32'h0);
    check({tag, "_r_changed"}, 32'(bus.r_changed), 32'h0);
    check({tag, "_max_n_osc"}, 32'(bus.max_n_osc), 32'h7);
    check({tag, "_osc_mask"},  32'(bus.osc_mask),  32'hFF);
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    vecs[0] = '{1,   10'h118, 3'd7, 8'hFF};
    vecs[1] = '{122, 10'h300, 3'd7, 8'hFF};
    vecs[2] = '{1,   10'h301, 3'd7, 8'hFF};
    vecs[3] = '{158, 10'h39F, 3'd7, 8'hFF};
    vecs[4] = '{1,   10'h3A0, 3'd5, 8'h3F};
    vecs[5] = '{1,   10'h3A1, 3'd5, 8'h3F};
    vecs[6] = '{23,  10'h3B8, 3'd4, 8'h1F};
    vecs[7] = '{24,  10'h3D0, 3'd5, 8'h3F};
    vecs[8] = '{12,  10'h3DC, 3'd7, 8'hFF};
    vecs[9] = '{35,  10'h3FF, 3'd7, 8'hFF};

    reset          = 1'b1;
    bus.next_ready = 1'b0;
    bus.hold       = 1'b0;
    bus.manual     = 1'b0;
    bus.step_up    = 1'b0;
    bus.step_down  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_values("rst");
    reset = 1'b0;

    // auto mode: 2 discarded pulses, 3 accepted, then an up step
    for (int p = 1; p <= 5; p++) begin
      check($sformatf("x_accept_pulse%0d", p), 32'(bus.x_accept), (p >= 3) ? 32'h1 : 32'h0);
      pulse();
    end
    check("step_x_accept", 32'(bus.x_accept), 32'h0);
    check("step_r_old",    32'(bus.r),        32'h110);
    @(posedge clk); #1;
    check("auto1_r",         32'(bus.r),         32'h114);
    check("auto1_r_changed", 32'(bus.r_changed), 32'h1);
    @(posedge clk); #1;
    check("auto1_r_changed_drop", 32'(bus.r_changed), 32'h0);

    // manual step-up sweep with region checkpoints
    bus.manual = 1'b1;
    for (int v = 0; v < 10; v++) begin
      for (int s = 0; s < vecs[v].n_steps; s++) begin
        do_step(1'b1);
      end
      check($sformatf("vec%0d_r", v),         32'(bus.r),         32'(vecs[v].exp_r));
      check($sformatf("vec%0d_max", v),       32'(bus.max_n_osc), 32'(vecs[v].exp_max));
      check($sformatf("vec%0d_mask", v),      32'(bus.osc_mask),  32'(vecs[v].exp_mask));
      check($sformatf("vec%0d_r_changed", v), 32'(bus.r_changed), 32'h1);
    end

    // auto step from 3.996 wraps to INITIAL_R
    bus.manual = 1'b0;
    repeat (5) pulse();
    @(posedge clk); #1;
    check("wrap_r",         32'(bus.r),         32'h110);
    check("wrap_max",       32'(bus.max_n_osc), 32'h7);
    check("wrap_mask",      32'(bus.osc_mask),  32'hFF);
    check("wrap_r_changed", 32'(bus.r_changed), 32'h1);

    // manual down steps and clamp at the floor
    bus.manual = 1'b1;
    do_step(1'b1);
    check("up_r", 32'(bus.r), 32'h114);
    do_step(1'b0);
    check("down_r",         32'(bus.r),         32'h110);
    check("down_r_changed", 32'(bus.r_changed), 32'h1);
    repeat (2) pulse();
    check("play_x_accept", 32'(bus.x_accept), 32'h1);
    bus.step_up   = 1'b1;
    bus.step_down = 1'b1;
    @(posedge clk); #1;
    bus.step_up   = 1'b0;
    bus.step_down = 1'b0;
    check("both_x_accept", 32'(bus.x_accept), 32'h1);
    @(posedge clk); #1;
    check("both_x_accept2", 32'(bus.x_accept), 32'h1);
    check("both_r",         32'(bus.r),        32'h110);
    bus.step_down = 1'b1;
    @(posedge clk); #1;
    bus.step_down = 1'b0;
    check("clamp_step_x_accept", 32'(bus.x_accept), 32'h0);
    @(posedge clk); #1;
    check("clamp_r",         32'(bus.r),         32'h110);
    check("clamp_r_changed", 32'(bus.r_changed), 32'h0);

    // hold freezes counting during PLAY
    bus.manual = 1'b0;
    repeat (2) pulse();
    bus.hold = 1'b1;
    repeat (10) pulse();
    check("hold_x_accept", 32'(bus.x_accept), 32'h1);
    check("hold_r",        32'(bus.r),        32'h110);
    bus.hold = 1'b0;
    repeat (2) pulse();
    check("release_x_accept", 32'(bus.x_accept), 32'h1);
    pulse();
    check("release_step_x_accept", 32'(bus.x_accept), 32'h0);
    @(posedge clk); #1;
    check("release_r",         32'(bus.r),         32'h114);
    check("release_r_changed", 32'(bus.r_changed), 32'h1);

    // reset in the cycle after STEP
    reset = 1'b1;
    @(posedge clk); #1;
    check_reset_values("midrst");
    reset = 1'b0;

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
